// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter sharing one i2c master between N requesters, with a
// transaction watchdog that aborts the master and flags the owning requester.
module i2c_req_arbiter #(
  parameter int unsigned N       = 4,
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic [8*N-1:0]   req_addr_rw,
  input  logic [8*N-1:0]   req_cnt,
  output logic [N-1:0]     gnt,
  output logic [N-1:0]     done,
  output logic [N-1:0]     err,
  output logic             m_ready,
  output logic [7:0]       m_addr_rw,
  output logic [7:0]       m_cnt,
  input  logic             m_done,
  output logic             m_abort,
  output logic             busy
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned WW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   owner, owner_nxt;
  logic [IW-1:0]   ptr, ptr_nxt;
  logic [WW-1:0]   wd, wd_nxt;
  logic [N-1:0]    gnt_nxt, done_nxt, err_nxt;
  logic            m_ready_nxt, m_abort_nxt, busy_nxt;
  logic [7:0]      m_addr_rw_nxt, m_cnt_nxt;

  logic            pick_found;
  logic [IW-1:0]   pick_idx;
  logic [IW-1:0]   cand;
  logic            wd_expired;

  // Round-robin search starting just after the last served requester
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      cand = IW'((32'(ptr) + i) % N);
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign wd_expired = (TIMEOUT != 0) && (wd == WW'(TIMEOUT - 1));

  always_comb begin
    state_nxt     = state;
    owner_nxt     = owner;
    ptr_nxt       = ptr;
    wd_nxt        = wd;
    gnt_nxt       = gnt;
    done_nxt      = '0;
    err_nxt       = '0;
    m_ready_nxt   = m_ready;
    m_addr_rw_nxt = m_addr_rw;
    m_cnt_nxt     = m_cnt;
    m_abort_nxt   = 1'b0;

    case (state)
      IDLE: begin
        gnt_nxt       = '0;
        m_ready_nxt   = 1'b0;
        m_addr_rw_nxt = '0;
        m_cnt_nxt     = '0;
        if (pick_found) begin
          owner_nxt     = pick_idx;
          ptr_nxt       = pick_idx;
          wd_nxt        = '0;
          gnt_nxt       = N'(1) << pick_idx;
          m_ready_nxt   = 1'b1;
          m_addr_rw_nxt = req_addr_rw[32'(pick_idx)*8 +: 8];
          m_cnt_nxt     = req_cnt[32'(pick_idx)*8 +: 8];
          state_nxt     = BUSY;
        end
      end
      BUSY: begin
        // m_done takes priority over a simultaneous watchdog expiry
        if (m_done) begin
          done_nxt      = N'(1) << owner;
          gnt_nxt       = '0;
          m_ready_nxt   = 1'b0;
          m_addr_rw_nxt = '0;
          m_cnt_nxt     = '0;
          state_nxt     = RELEASE;
        end else if (wd_expired) begin
          err_nxt       = N'(1) << owner;
          m_abort_nxt   = 1'b1;
          gnt_nxt       = '0;
          m_ready_nxt   = 1'b0;
          m_addr_rw_nxt = '0;
          m_cnt_nxt     = '0;
          state_nxt     = RELEASE;
        end else if (wd != {WW{1'b1}}) begin
          wd_nxt = wd + WW'(1);
        end
      end
      RELEASE: begin
        // one-cycle low gap on m_ready so the master cannot restart
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= '0;
      ptr       <= IW'(N - 1);
      wd        <= '0;
      gnt       <= '0;
      done      <= '0;
      err       <= '0;
      m_ready   <= 1'b0;
      m_addr_rw <= '0;
      m_cnt     <= '0;
      m_abort   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      owner     <= owner_nxt;
      ptr       <= ptr_nxt;
      wd        <= wd_nxt;
      gnt       <= gnt_nxt;
      done      <= done_nxt;
      err       <= err_nxt;
      m_ready   <= m_ready_nxt;
      m_addr_rw <= m_addr_rw_nxt;
      m_cnt     <= m_cnt_nxt;
      m_abort   <= m_abort_nxt;
      busy      <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Directed bench for i2c_req_arbiter: one instance with the default watchdog,
// one with TIMEOUT=20 for the abort and collision cases.
module tb_i2c_req_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_addr_rw;
  logic [31:0] req_cnt;
  logic        md0, md1;

  logic [3:0]  gnt0, done0, err0;
  logic        m_ready0, m_abort0, busy0;
  logic [7:0]  m_addr_rw0, m_cnt0;

  logic [3:0]  gnt1, done1, err1;
  logic        m_ready1, m_abort1, busy1;
  logic [7:0]  m_addr_rw1, m_cnt1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  i2c_req_arbiter #(.N(4)) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr_rw(req_addr_rw), .req_cnt(req_cnt),
    .gnt(gnt0), .done(done0), .err(err0), .m_ready(m_ready0), .m_addr_rw(m_addr_rw0),
    .m_cnt(m_cnt0), .m_done(md0), .m_abort(m_abort0), .busy(busy0)
  );

  i2c_req_arbiter #(.N(4), .TIMEOUT(20)) dut_wd (
    .clk(clk), .rst(rst), .req(req), .req_addr_rw(req_addr_rw), .req_cnt(req_cnt),
    .gnt(gnt1), .done(done1), .err(err1), .m_ready(m_ready1), .m_addr_rw(m_addr_rw1),
    .m_cnt(m_cnt1), .m_done(md1), .m_abort(m_abort1), .busy(busy1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; req = '0; req_addr_rw = '0; req_cnt = '0; md0 = 1'b0; md1 = 1'b0;
    step(2);
    chk("rst_gnt", 32'(gnt0), 0);
    chk("rst_ready", 32'(m_ready0), 0);
    chk("rst_busy", 32'(busy0), 0);
    chk("rst_addr", 32'(m_addr_rw0), 0);
    chk("rst_abort", 32'(m_abort1), 0);

    // single requester
    rst = 1'b0;
    req = 4'b0100; req_addr_rw[23:16] = 8'hA1; req_cnt[23:16] = 8'd3;
    step(1);
    chk("single_gnt", 32'(gnt0), 32'h4);
    chk("single_ready", 32'(m_ready0), 1);
    chk("single_addr", 32'(m_addr_rw0), 32'hA1);
    chk("single_cnt", 32'(m_cnt0), 3);
    chk("single_busy", 32'(busy0), 1);
    req = '0;
    step(49);
    chk("single_hold_gnt", 32'(gnt0), 32'h4);
    md0 = 1'b1;
    step(1);
    md0 = 1'b0;
    chk("single_done", 32'(done0), 32'h4);
    chk("single_gnt_off", 32'(gnt0), 0);
    chk("single_ready_off", 32'(m_ready0), 0);
    chk("single_busy_rel", 32'(busy0), 1);
    step(1);
    chk("single_done_pulse", 32'(done0), 0);
    chk("single_idle", 32'(busy0), 0);

    // round robin from a fresh pointer
    rst = 1'b1;
    step(1);
    rst = 1'b0; req = 4'b1111;
    step(1);
    for (int k = 0; k < 5; k++) begin
      chk("rr_gnt", 32'(gnt0), 32'(1) << (k % 4));
      chk("rr_ready", 32'(m_ready0), 1);
      step(9);
      md0 = 1'b1;
      step(1);
      md0 = 1'b0;
      chk("rr_done", 32'(done0), 32'(1) << (k % 4));
      chk("rr_err", 32'(err0), 0);
      step(1);
      chk("rr_gap", 32'(busy0), 0);
      chk("rr_gap_gnt", 32'(gnt0), 0);
      if (k == 4) req = '0;
      step(1);
    end

    // m_done while idle is ignored
    md0 = 1'b1;
    step(1);
    md0 = 1'b0;
    chk("idle_mdone_done", 32'(done0), 0);
    chk("idle_mdone_busy", 32'(busy0), 0);

    // input churn during BUSY
    req = 4'b0001; req_addr_rw[7:0] = 8'h5A; req_cnt[7:0] = 8'd7;
    step(1);
    chk("churn_gnt", 32'(gnt0), 32'h1);
    chk("churn_addr0", 32'(m_addr_rw0), 32'h5A);
    req_addr_rw[7:0] = 8'hFF; req_cnt[7:0] = 8'd1; req = '0;
    step(5);
    chk("churn_addr", 32'(m_addr_rw0), 32'h5A);
    chk("churn_cnt", 32'(m_cnt0), 7);
    chk("churn_hold_gnt", 32'(gnt0), 32'h1);
    md0 = 1'b1;
    step(1);
    md0 = 1'b0;
    chk("churn_done", 32'(done0), 32'h1);
    step(2);

    // asynchronous reset mid-transaction
    req = 4'b0010;
    step(1);
    chk("rstb_gnt", 32'(gnt0), 32'h2);
    step(3);
    #2;
    rst = 1'b1;
    #1;
    chk("rstb_gnt_async", 32'(gnt0), 0);
    chk("rstb_ready_async", 32'(m_ready0), 0);
    chk("rstb_busy_async", 32'(busy0), 0);
    chk("rstb_done_async", 32'(done0), 0);
    step(1);
    rst = 1'b0; req = 4'b1111;
    step(1);
    chk("rstb_first", 32'(gnt0), 32'h1);
    chk("wd_first", 32'(gnt1), 32'h1);

    // watchdog abort on the TIMEOUT=20 instance
    step(19);
    chk("wd_pre_err", 32'(err1), 0);
    chk("wd_pre_gnt", 32'(gnt1), 32'h1);
    step(1);
    chk("wd_err", 32'(err1), 32'h1);
    chk("wd_abort", 32'(m_abort1), 1);
    chk("wd_gnt_off", 32'(gnt1), 0);
    chk("wd_no_done", 32'(done1), 0);
    chk("wd_ready_off", 32'(m_ready1), 0);
    step(1);
    chk("wd_err_pulse", 32'(err1), 0);
    chk("wd_abort_pulse", 32'(m_abort1), 0);
    step(1);
    chk("wd_next_gnt", 32'(gnt1), 32'h2);

    // m_done on the expiry cycle wins
    step(19);
    md1 = 1'b1;
    step(1);
    md1 = 1'b0;
    chk("col_done", 32'(done1), 32'h2);
    chk("col_err", 32'(err1), 0);
    chk("col_abort", 32'(m_abort1), 0);
    chk("col_gnt", 32'(gnt1), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
